// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, W data bits, optional even-parity bit, stop bit.
// Words are delivered through a valid/ready output register with sticky overrun.
module serial_frame_rx #(
  parameter int W         = 4,
  parameter bit PARITY_EN = 1'b1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         sclr,
  input  logic         en,
  input  logic         SI,
  output logic [W-1:0] data,
  output logic         valid,
  input  logic         ready,
  output logic         parity_err,
  output logic         frame_err,
  output logic         overrun,
  output logic         busy
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   shreg;
  logic           par_bit;

  logic [W-1:0]   shift_next;
  logic           last_bit;
  logic           word_perr;
  logic           deliver;

  // Handshake: data/parity_err are held while valid=1 and the word is consumed
  // on any edge where valid=1 and ready=1. A delivery on that same edge reloads.
  always_comb begin
    shift_next = MSB_FIRST ? {shreg[W-2:0], SI} : {SI, shreg[W-1:1]};
    last_bit   = (cnt == CW'(W - 1));
    word_perr  = PARITY_EN ? ((^shreg) ^ par_bit) : 1'b0;
    deliver    = (state == STOP) && en && SI;
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      if (en) begin
        case (state)
          IDLE: begin
            if (!SI) begin
              state <= DATA;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          DATA: begin
            shreg <= shift_next;
            cnt   <= cnt + 1'b1;
            if (last_bit) begin
              if (PARITY_EN) state <= PARITY;
              else           state <= STOP;
            end
          end
          PARITY: begin
            par_bit <= SI;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!SI) frame_err <= 1'b1;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end

      // An unconsumed word is never overwritten; the newcomer is dropped instead.
      if (deliver) begin
        if (!valid || ready) begin
          data       <= shreg;
          parity_err <= word_perr;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed frames with literal expectations, then
// randomized frames compared every cycle against a frame-level reference model.
module tb_serial_frame_rx;

  localparam int W         = 4;
  localparam bit PARITY_EN = 1'b1;
  localparam bit MSB_FIRST = 1'b1;

  logic         clk = 1'b0;
  logic         sclr, en, SI, ready;
  logic [W-1:0] data;
  logic         valid, parity_err, frame_err, overrun, busy;

  serial_frame_rx #(.W(W), .PARITY_EN(PARITY_EN), .MSB_FIRST(MSB_FIRST)) dut (
    .clk        (clk),
    .sclr       (sclr),
    .en         (en),
    .SI         (SI),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ferr_cnt = 0;
  int rdy_mode = 0;  // 0: ready low, 1: ready high, 2: random each cycle

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // reference model: tracks the frame position and collects the data bits
  int           m_phase;     // 0 idle, 1 data, 2 parity, 3 stop
  int           bits[$];
  int           m_pbit;
  logic [W-1:0] m_data;
  logic         m_valid, m_perr, m_ferr, m_ovr, m_busy;
  bit           model_live = 1'b0;

  always @(posedge clk) begin : model
    bit dlv;
    int word;
    int ones;
    dlv    = 1'b0;
    m_ferr = 1'b0;
    if (sclr) begin
      m_phase = 0;
      bits.delete();
      m_pbit  = 0;
      m_data  = '0;
      m_valid = 1'b0;
      m_perr  = 1'b0;
      m_ovr   = 1'b0;
      m_busy  = 1'b0;
      model_live = 1'b1;
    end else begin
      if (en) begin
        case (m_phase)
          0: if (!SI) begin m_phase = 1; bits.delete(); end
          1: begin
            bits.push_back(int'(SI));
            if (bits.size() == W) m_phase = PARITY_EN ? 2 : 3;
          end
          2: begin m_pbit = int'(SI); m_phase = 3; end
          default: begin
            if (SI) dlv = 1'b1;
            else    m_ferr = 1'b1;
            m_phase = 0;
          end
        endcase
      end
      if (dlv) begin
        word = 0;
        ones = 0;
        foreach (bits[i]) begin
          ones += bits[i];
          if (MSB_FIRST) word = word * 2 + bits[i];
          else           word = word + (bits[i] << i);
        end
        if (!m_valid || ready) begin
          m_data  = W'(word);
          m_perr  = PARITY_EN ? ((ones + m_pbit) % 2 == 1) : 1'b0;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
      m_busy = (m_phase != 0);
    end
  end

  // scoreboard compare: every cycle, away from the active edge
  always @(negedge clk) begin
    if (model_live) begin
      check("data",       32'(data),       32'(m_data));
      check("valid",      32'(valid),      32'(m_valid));
      check("parity_err", 32'(parity_err), 32'(m_perr));
      check("frame_err",  32'(frame_err),  32'(m_ferr));
      check("overrun",    32'(overrun),    32'(m_ovr));
      check("busy",       32'(busy),       32'(m_busy));
      if (frame_err === 1'b1) ferr_cnt++;
    end
  end

  // driver tasks
  task automatic set_ready();
    ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en = 1'b1; SI = 1'b1; set_ready();
    end
  endtask

  task automatic send_bit(input logic b, input int gaps);
    repeat (gaps) begin
      @(negedge clk);
      en = 1'b0; SI = 1'($urandom_range(0, 1)); set_ready();
    end
    @(negedge clk);
    en = 1'b1; SI = b; set_ready();
  endtask

  // stop_rdy >= 0 forces ready for the stop-bit cycle only
  task automatic send_frame(input logic [W-1:0] w, input logic p, input logic stop,
                            input int gaps, input int stop_rdy);
    int saved;
    send_bit(1'b0, gaps);
    for (int i = 0; i < W; i++) send_bit(MSB_FIRST ? w[W-1-i] : w[i], gaps);
    if (PARITY_EN) send_bit(p, gaps);
    saved = rdy_mode;
    if (stop_rdy >= 0) rdy_mode = stop_rdy;
    send_bit(stop, gaps);
    rdy_mode = saved;
    @(negedge clk);
    en = 1'b0; SI = 1'b1; set_ready();
  endtask

  task automatic do_reset();
    @(negedge clk);
    sclr = 1'b1; en = 1'b0; SI = 1'b1; ready = 1'b0;
    @(negedge clk);
    sclr = 1'b0;
  endtask

  initial begin
    int base;
    logic [W-1:0] w;
    logic p;
    sclr = 1'b1; en = 1'b0; SI = 1'b1; ready = 1'b0;

    // reset state
    do_reset();
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);

    // good frame
    rdy_mode = 0;
    send_frame(4'b1101, 1'b1, 1'b1, 0, -1);
    check("good_data", 32'(data), 32'hD);
    check("good_valid", 32'(valid), 32'h1);
    check("good_perr", 32'(parity_err), 32'h0);
    check("good_busy", 32'(busy), 32'h0);

    // parity error
    do_reset();
    send_frame(4'b1101, 1'b0, 1'b1, 0, -1);
    check("perr_data", 32'(data), 32'hD);
    check("perr_valid", 32'(valid), 32'h1);
    check("perr_flag", 32'(parity_err), 32'h1);

    // framing error
    do_reset();
    send_frame(4'b1010, 1'b0, 1'b0, 0, -1);
    check("ferr_pulse", 32'(frame_err), 32'h1);
    check("ferr_valid", 32'(valid), 32'h0);
    check("ferr_data", 32'(data), 32'h0);
    idle(1);
    check("ferr_one_cycle", 32'(frame_err), 32'h0);

    // overrun, then consume
    do_reset();
    send_frame(4'b1101, 1'b1, 1'b1, 0, -1);
    send_frame(4'b0011, 1'b0, 1'b1, 0, -1);
    check("ovr_data", 32'(data), 32'hD);
    check("ovr_flag", 32'(overrun), 32'h1);
    check("ovr_valid", 32'(valid), 32'h1);
    rdy_mode = 1;
    idle(1);
    rdy_mode = 0;
    idle(1);
    check("consume_valid", 32'(valid), 32'h0);
    check("ovr_sticky", 32'(overrun), 32'h1);

    // delivery coinciding with consumption
    do_reset();
    send_frame(4'b1101, 1'b1, 1'b1, 0, -1);
    send_frame(4'b0011, 1'b0, 1'b1, 0, 1);
    check("hs_data", 32'(data), 32'h3);
    check("hs_valid", 32'(valid), 32'h1);
    check("hs_overrun", 32'(overrun), 32'h0);

    // en gating
    do_reset();
    send_frame(4'b1101, 1'b1, 1'b1, 2, -1);
    check("gate_data", 32'(data), 32'hD);
    check("gate_valid", 32'(valid), 32'h1);
    check("gate_perr", 32'(parity_err), 32'h0);

    // reset mid-frame
    do_reset();
    base = ferr_cnt;
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    @(negedge clk);
    sclr = 1'b1; en = 1'b1; SI = 1'b0; ready = 1'b1;
    @(negedge clk);
    sclr = 1'b0; en = 1'b0; SI = 1'b1; ready = 1'b0;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_valid", 32'(valid), 32'h0);
    send_frame(4'b1010, 1'b0, 1'b1, 0, -1);
    check("midrst_data", 32'(data), 32'hA);
    check("midrst_valid2", 32'(valid), 32'h1);
    check("midrst_noferr", 32'(ferr_cnt - base), 32'h0);

    // randomized frames
    do_reset();
    rdy_mode = 2;
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 19) == 0) begin
        send_bit(1'b0, 0);
        repeat ($urandom_range(0, W)) send_bit(1'($urandom_range(0, 1)), 0);
        @(negedge clk);
        sclr = 1'b1; en = 1'($urandom_range(0, 1)); SI = 1'($urandom_range(0, 1));
        @(negedge clk);
        sclr = 1'b0;
      end
      w = W'($urandom);
      p = ($urandom_range(0, 3) == 0) ? ~(^w) : (^w);
      send_frame(w, p, ($urandom_range(0, 7) != 0), $urandom_range(0, 2), -1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    rdy_mode = 0;
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
